modred_mont_iter: RTL and testbench
===================================

# modred_mont_iter

Digit-serial Montgomery reduction stage placed directly downstream of `intmul_standard`. It takes the 2W-bit integer product C = A·B and returns C·2^-W mod q, a W-bit residue fully reduced into [0, q). One W_D-bit digit is reduced per cycle, then one conditional-subtract cycle runs. Valid/ready handshakes on both sides let it absorb the multiplier's fixed-latency output stream with a small skid FIFO in front.

## Interface
- `W`, 64, modulus and result width; must be a multiple of `W_D`.
- `W_D`, 16, digit width reduced per iteration; N = W/W_D iterations.
- `clk`  in  1  clock, rising-edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  `T`/`q`/`qinv` valid.
- `in_ready`  out  1  block can accept an operand.
- `T`  in  2W  product to reduce; precondition T < q·2^W.
- `q`  in  W  modulus; odd, q < 2^W.
- `qinv`  in  W_D  −q^-1 mod 2^W_D.
- `out_valid`  out  1  `C` valid.
- `out_ready`  in  1  downstream accepts `C`.
- `C`  out  W  result T·2^-W mod q.

## Operation
- Registers:
  - accumulator `acc`, 2W+1 bits.
  - `q_r`, W bits.
  - `qinv_r`, W_D bits.
  - iteration counter `cnt`, ceil(log2 N) bits, minimum 1.
  - `C` register, W bits.
- FSM states: IDLE, ITER, CORR, DONE.
- IDLE: `in_ready`=1. On `in_valid`&`in_ready`: `acc`←{0,T}, `q_r`←q, `qinv_r`←qinv, `cnt`←0, go to ITER.
- ITER, one digit per cycle:
  - m = (acc[W_D-1:0]·qinv_r) mod 2^W_D.
  - acc ← (acc + m·q_r) >> W_D. The low W_D bits of the sum are zero by construction.
  - `cnt`++. When `cnt`=N−1 this cycle, go to CORR.
- CORR: D = acc − q_r, computed at W+1 bits.
  - If acc ≥ q_r, `C`←D[W-1:0]; else `C`←acc[W-1:0].
  - Set `out_valid`, go to DONE.
- DONE: `out_valid`=1, `C` held. On `out_ready`: clear `out_valid`, go to IDLE.
- Width rule: acc < 2q holds after the last iteration, so acc[2W:W+1] is zero entering CORR. This is a checked assertion, not a truncation.
- `in_ready` is asserted only in IDLE. There is no input accept in DONE, even when `out_ready`=1.
- Inputs are sampled only at the accept edge. `T`/`q`/`qinv` may change freely afterwards.
- Precondition violation (T ≥ q·2^W, or even q) produces an undefined `C`, but the FSM timing is unchanged.

## Timing
- Reset (async assert, any state) forces:
  - state=IDLE, `in_ready`=1, `out_valid`=0, `C`=0, `acc`=0, `cnt`=0.
  - In-flight work is discarded. Handshakes while `rst`=1 have no effect.
- Latency: accept at edge e0 → iterations at e1…eN → CORR at e(N+1) → `out_valid`=1 after e(N+1).
  - Accept-to-valid is N+1 cycles; for the defaults, 5 cycles.
- Output transfer happens at the edge where `out_valid`&`out_ready`. `in_ready` rises in the following cycle.
- Throughput with `out_ready` tied high: one result per N+3 cycles.
- Back-pressure: `out_valid` and `C` stay stable indefinitely until `out_ready`. `in_ready` stays 0 throughout.
- `out_ready` high before `out_valid` is ignored.

## Test plan
Defaults W=64, W_D=16, q=0xFFFFFFFFFFFFFFC5, `qinv` precomputed by the bench.
- T=0 accepted at edge e0 → `out_valid` rises 5 cycles later, C=0. `in_ready`=0 from e0 until the cycle after the output transfer.
- T=q (0x…FFC5 in the low half, high half 0) → acc=q entering CORR, correction taken, C=0.
- T=5·2^64 → C=5. T=(q−1)·2^64 → C=q−1, the maximum residue with no correction.
- 1000 random T<q·2^64 with random `in_valid`/`out_ready` gaps → every C equals T·2^-64 mod q from a bench reference model. Also check:
  - no result is lost or duplicated.
  - `C` is stable whenever `out_valid`&!`out_ready`.
- Hold `out_ready`=0 for 10 cycles after `out_valid` → C unchanged, `in_ready`=0. Raise `out_ready` for 1 cycle → `out_valid`=0 and `in_ready`=1 on the next cycle.
- Assert `rst` during ITER (cnt=2) between clock edges → outputs immediately at reset values. After release, T=2^64 accepted → C=1 with no residue of the aborted operand.

Source files
------------

// File: rtl/modred_mont_iter.sv
// Purpose: digit-serial Montgomery reduction, C = T * 2^-W mod q, fully reduced into [0, q).
// Latency: accept to out_valid is N+1 cycles (N = W/W_D digit steps + 1 correction); one result per N+3 cycles.
// Backpressure: in_ready only in IDLE; out_valid/C hold indefinitely until out_ready, no new accept meanwhile.
//
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready    operand handshake for T (2W), q (W, odd), qinv (W_D, -q^-1 mod 2^W_D)
//   out_valid / out_ready  result handshake for C (W)
module modred_mont_iter #(
  parameter int W   = 64,
  parameter int W_D = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W-1:0]   T,
  input  logic [W-1:0]     q,
  input  logic [W_D-1:0]   qinv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     C
);

  localparam int N  = W / W_D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, ITER, CORR, DONE} state_t;

  state_t          state;
  logic [2*W:0]    acc;
  logic [W-1:0]    q_r;
  logic [W_D-1:0]  qinv_r;
  logic [CW-1:0]   cnt;

  // m is taken mod 2^W_D simply by the W_D-bit result width.
  logic [W_D-1:0]     m;
  logic [W+W_D-1:0]   mq;
  logic [2*W+W_D:0]   sum;
  logic [W:0]         diff;

  assign m    = acc[W_D-1:0] * qinv_r;
  assign mq   = {{W{1'b0}}, m} * {{W_D{1'b0}}, q_r};
  assign sum  = {{W_D{1'b0}}, acc} + {{(W+1){1'b0}}, mq};
  // acc < 2q < 2^(W+1) here, so the (W+1)-bit difference is a valid signed
  // value and its top bit is the borrow (acc < q_r).
  assign diff = acc[W:0] - {1'b0, q_r};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      C         <= '0;
      acc       <= '0;
      q_r       <= '0;
      qinv_r    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            acc      <= {1'b0, T};
            q_r      <= q;
            qinv_r   <= qinv;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= ITER;
          end
        end
        ITER: begin
          // Low W_D bits of sum are zero by choice of m; drop them.
          acc <= sum[2*W+W_D:W_D];
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= CORR;
          end
        end
        CORR: begin
          C         <= diff[W] ? acc[W-1:0] : diff[W-1:0];
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The digit step must cancel the low digit exactly (q odd, qinv correct).
  a_digit_zero: assert property (@(posedge clk) disable iff (rst)
    (state == ITER) |-> (sum[W_D-1:0] == '0));

  // After the last digit acc < 2q, so nothing lives above bit W.
  a_acc_range: assert property (@(posedge clk) disable iff (rst)
    (state == CORR) |-> (acc[2*W:W+1] == '0));

endmodule

// File: tb/tb_modred_mont_iter.sv
module tb_modred_mont_iter;

  localparam int W  = 64;
  localparam int WD = 16;
  localparam int NR = 1000;
  localparam logic [63:0] QM   = 64'hFFFFFFFFFFFFFFC5;
  // -q^-1 mod 2^16: low digit of q is -59, so this is 59^-1 mod 2^16 = 55539.
  localparam logic [15:0] QINV = 16'hD8F3;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  T;
  logic [63:0]   q;
  logic [15:0]   qinv;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   C;

  int checks;
  int errors;

  modred_mont_iter #(.W(W), .W_D(WD)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .T         (T),
    .q         (q),
    .qinv      (qinv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .C         (C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: reduce mod q, then halve mod q 64 times.
  function automatic logic [63:0] mont_ref(input logic [127:0] t);
    logic [128:0] r;
    r = {1'b0, t % {64'd0, QM}};
    for (int i = 0; i < 64; i++) begin
      r = r[0] ? ((r + {65'd0, QM}) >> 1) : (r >> 1);
    end
    return r[63:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operand, waits for its result and takes it; no comparisons here.
  task automatic run_one(input logic [127:0] t, output logic [63:0] c, output int lat, output bit ok);
    bit got;
    got = 1'b0;
    lat = 0;
    T = t; q = QM; qinv = QINV; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      got = in_ready;
      tick();
    end
    in_valid = 1'b0;
    T = ~t; q = ~QM; qinv = ~QINV;
    for (int i = 0; i < 30 && !out_valid; i++) begin
      tick();
      lat++;
    end
    c = C;
    ok = got && out_valid;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; T = '0; q = QM; qinv = QINV;
    #3;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (C !== 64'd0) begin errors++; $display("FAIL reset_C got %h want 0", C); end
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle in_ready %b out_valid %b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_latency();
    int n;
    T = '0; q = QM; qinv = QINV; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; T = {2{64'hDEADBEEFCAFEF00D}};
    n = 0;
    while (!out_valid && n < 30) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lat_in_ready cycle %0d got %b want 0", n, in_ready); end
      tick();
      n++;
    end
    checks++; if (n != 5) begin errors++; $display("FAIL lat_cycles got %0d want 5", n); end
    checks++; if (C !== 64'd0) begin errors++; $display("FAIL lat_C got %h want 0", C); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lat_in_ready_done got %b want 0", in_ready); end
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL lat_after_xfer out_valid %b in_ready %b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_directed();
    logic [127:0] tv [3];
    logic [63:0]  ev [3];
    logic [63:0]  c;
    int lat;
    bit ok;
    tv[0] = {64'd0, QM};            ev[0] = 64'd0;
    tv[1] = {64'd5, 64'd0};         ev[1] = 64'd5;
    tv[2] = {QM - 64'd1, 64'd0};    ev[2] = QM - 64'd1;
    for (int i = 0; i < 3; i++) begin
      run_one(tv[i], c, lat, ok);
      checks++; if (!ok) begin errors++; $display("FAIL dir%0d_timeout no result", i); end
      checks++; if (c !== ev[i]) begin errors++; $display("FAIL dir%0d_C got %h want %h", i, c, ev[i]); end
      checks++; if (lat != 5) begin errors++; $display("FAIL dir%0d_latency got %0d want 5", i, lat); end
    end
  endtask

  task automatic test_backpressure();
    int n;
    T = {64'd5, 64'd0}; q = QM; qinv = QINV; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 30) begin tick(); n++; end
    checks++; if (out_valid !== 1'b1 || C !== 64'd5) begin
      errors++; $display("FAIL bp_first out_valid %b C %h want 1/5", out_valid, C);
    end
    in_valid = 1'b1; T = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || C !== 64'd5 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold cycle %0d out_valid %b C %h in_ready %b want 1/5/0", i, out_valid, C, in_ready);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release out_valid %b in_ready %b want 0/1", out_valid, in_ready);
    end
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_done_accept in_ready %b want 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    int acc_cyc[$];
    int nres;
    nres = 0;
    T = {64'd3, 64'd0}; q = QM; qinv = QINV; in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && nres < 3; cyc++) begin
      if (in_valid && in_ready) acc_cyc.push_back(cyc);
      if (out_valid) begin
        nres++;
        checks++; if (C !== 64'd3) begin errors++; $display("FAIL b2b_C got %h want 3", C); end
      end
      tick();
      if (acc_cyc.size() >= 3) in_valid = 1'b0;
    end
    out_ready = 1'b0; in_valid = 1'b0;
    checks++; if (nres != 3 || acc_cyc.size() != 3) begin
      errors++; $display("FAIL b2b_count results %0d accepts %0d want 3/3", nres, acc_cyc.size());
    end else begin
      checks++; if (acc_cyc[1] - acc_cyc[0] != 7 || acc_cyc[2] - acc_cyc[1] != 7) begin
        errors++; $display("FAIL b2b_period got %0d,%0d want 7,7", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
      end
    end
  endtask

  task automatic test_reset_mid_iter();
    logic [63:0] c;
    int lat;
    bit ok;
    T = {QM - 64'd1, 64'd0}; q = QM; qinv = QINV; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    checks++; if (dut.cnt !== 2'd2) begin errors++; $display("FAIL mid_cnt got %0d want 2", dut.cnt); end
    #2 rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || C !== 64'd0) begin
      errors++; $display("FAIL mid_rst_outputs in_ready %b out_valid %b C %h want 1/0/0", in_ready, out_valid, C);
    end
    checks++; if (dut.cnt !== 2'd0 || dut.acc !== 129'd0) begin
      errors++; $display("FAIL mid_rst_state cnt %0d acc %h want 0/0", dut.cnt, dut.acc);
    end
    in_valid = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_handshake in_ready %b want 1", in_ready); end
    #2 rst = 1'b0; in_valid = 1'b0;
    tick();
    run_one({64'd1, 64'd0}, c, lat, ok);
    checks++; if (!ok || c !== 64'd1) begin errors++; $display("FAIL post_abort_C ok %b got %h want 1", ok, c); end
    checks++; if (lat != 5) begin errors++; $display("FAIL post_abort_latency got %0d want 5", lat); end
  endtask

  task automatic test_random();
    logic [63:0] exp_q[$];
    logic [63:0] held;
    logic [63:0] e;
    logic [63:0] hi;
    logic [63:0] lo;
    int sent;
    int recv;
    bit stall;
    bit acc_now;
    bit xfer;
    sent = 0; recv = 0;
    q = QM; qinv = QINV; in_valid = 1'b0; out_ready = 1'b0;
    for (int cyc = 0; cyc < 30000 && recv < NR; cyc++) begin
      acc_now = in_valid && in_ready;
      xfer = out_valid && out_ready;
      if (xfer) begin
        recv++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_extra_result got %h with nothing outstanding", C);
        end else begin
          e = exp_q.pop_front();
          if (C !== e) begin errors++; $display("FAIL rnd_C result %0d got %h want %h", recv, C, e); end
        end
      end
      if (acc_now) begin
        exp_q.push_back(mont_ref(T));
        sent++;
      end
      stall = out_valid && !out_ready;
      held = C;
      tick();
      if (stall) begin
        checks++; if (out_valid !== 1'b1 || C !== held) begin
          errors++; $display("FAIL rnd_stable out_valid %b C %h want 1/%h", out_valid, C, held);
        end
      end
      if (acc_now || !in_valid) begin
        if (sent < NR && $urandom_range(0, 3) != 0) begin
          hi = {$urandom, $urandom} % QM;
          lo = {$urandom, $urandom};
          T = {hi, lo};
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (sent != NR || recv != NR || exp_q.size() != 0) begin
      errors++; $display("FAIL rnd_count sent %0d recv %0d pending %0d want %0d/%0d/0", sent, recv, exp_q.size(), NR, NR);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_latency();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_iter();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
